// File: rtl/ysyx_23060180_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060180_mem_pkg
// Description : Address map, store-size encodings and strobe helpers for the
//               memory bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_23060180_mem_pkg;

   localparam logic [31:0] c_RAM_BASE    = 32'h8000_0000;
   localparam int          c_RAM_AW      = 14;
   localparam logic [31:0] c_SERIAL_ADDR = 32'ha000_03f8;
   localparam logic [31:0] c_RTC_ADDR    = 32'ha000_0048;
   localparam int          c_TXQ_DEPTH   = 4;

   localparam logic [3:0]  c_SZ_B = 4'd1;
   localparam logic [3:0]  c_SZ_H = 4'd2;
   localparam logic [3:0]  c_SZ_W = 4'd4;

   function automatic logic [3:0] size2strb(input logic [3:0] size, input logic [1:0] a);
      logic [3:0] strb;
      strb = 4'b0000;
      case (size)
         c_SZ_B:  strb = 4'b0001 << a;
         c_SZ_H:  strb = 4'b0011 << a;
         c_SZ_W:  strb = 4'b1111;
         default: strb = 4'b0000;
      endcase
      return strb;
   endfunction

   // Illegal sizes report as misaligned so one check covers both cases.
   function automatic logic is_aligned(input logic [3:0] size, input logic [1:0] a);
      logic ok;
      ok = 1'b0;
      case (size)
         c_SZ_B:  ok = 1'b1;
         c_SZ_H:  ok = ~a[0];
         c_SZ_W:  ok = (a == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060180_txq.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060180_txq
// Description : Small synchronous FIFO; head is visible combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060180_txq #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn_in,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);
   localparam int            c_AW   = $clog2(DEPTH);
   localparam logic [c_AW:0] c_FULL = (c_AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [0:DEPTH-1];
   logic [c_AW-1:0]  r_wptr;
   logic [c_AW-1:0]  r_rptr;
   logic [c_AW:0]    r_count;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign o_full    = (r_count == c_FULL);
   assign o_empty   = (r_count == '0);
   assign o_head    = o_empty ? '0 : r_mem[r_rptr];
   assign w_pop_ok  = i_pop & ~o_empty;
   // A push into a full queue still lands when the head leaves the same cycle.
   assign w_push_ok = i_push & (~o_full | w_pop_ok);

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wptr] <= i_data;
   end

   always_ff @(posedge clk or negedge rstn_in) begin
      if (!rstn_in) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + c_AW'(1);
         if (w_pop_ok)  r_rptr <= r_rptr + c_AW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + (c_AW+1)'(1);
            2'b01:   r_count <= r_count - (c_AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060180_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060180_mem_bridge
// Description : Zero-stall memory stage: RAM, serial TX queue and 64-bit RTC.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060180_mem_bridge
   import ysyx_23060180_mem_pkg::*;
#(
   parameter logic [31:0] RAM_BASE    = c_RAM_BASE,
   parameter int          RAM_AW      = c_RAM_AW,
   parameter logic [31:0] SERIAL_ADDR = c_SERIAL_ADDR,
   parameter logic [31:0] RTC_ADDR    = c_RTC_ADDR,
   parameter int          TXQ_DEPTH   = c_TXQ_DEPTH
) (
   input  logic        clk,
   input  logic        rstn_in,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [31:0] mem_raddr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wbit_en,
   output logic [31:0] mem_rdata,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        access_err,
   output logic [7:0]  err_cnt
);
   localparam logic [31:0] c_RTC_HI_ADDR = RTC_ADDR + 32'd4;

   logic [31:0]       r_ram [0:(2**RAM_AW)-1];
   logic [31:0]       r_rdata;
   logic              r_access_err;
   logic [7:0]        r_err_cnt;
   logic [63:0]       r_rtc;
   logic [31:0]       r_rtc_hi_snap;

   logic [1:0]        w_lane;
   logic [4:0]        w_shamt;
   logic [RAM_AW-1:0] w_idx;
   logic              w_in_ram, w_is_ser, w_is_rtc_lo, w_is_rtc_hi;
   logic              w_txq_full, w_txq_empty, w_pop, w_push;
   logic              w_ser_wr, w_ram_we, w_wr_err, w_rd_err, w_err;
   logic [3:0]        w_strb;
   logic [31:0]       w_wlane, w_ram_word, w_merged, w_rd_word;

   assign w_lane      = mem_raddr[1:0];
   assign w_shamt     = {w_lane, 3'b000};
   assign w_idx       = mem_raddr[RAM_AW+1:2];
   assign w_in_ram    = (mem_raddr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]);
   assign w_is_ser    = (mem_raddr == SERIAL_ADDR);
   assign w_is_rtc_lo = (mem_raddr == RTC_ADDR);
   assign w_is_rtc_hi = (mem_raddr == c_RTC_HI_ADDR);

   assign w_ser_wr = mem_wr & w_is_ser & (mem_wbit_en == c_SZ_B);
   assign w_ram_we = mem_wr & w_in_ram & is_aligned(mem_wbit_en, w_lane);
   assign w_pop    = ~w_txq_empty & tx_ready;
   assign w_push   = w_ser_wr & (~w_txq_full | w_pop);
   // Anything that is neither a legal RAM store nor a serial byte store is dropped.
   assign w_wr_err = (mem_wr & ~(w_ram_we | w_ser_wr)) | (w_ser_wr & w_txq_full & ~w_pop);
   assign w_rd_err = mem_rd & ~(w_in_ram | w_is_ser | w_is_rtc_lo | w_is_rtc_hi);
   assign w_err    = w_wr_err | w_rd_err;

   assign w_strb     = w_ram_we ? size2strb(mem_wbit_en, w_lane) : 4'b0000;
   assign w_wlane    = mem_wdata << w_shamt;
   assign w_ram_word = r_ram[w_idx];

   // Write-first: a read in the same cycle sees the freshly stored lanes.
   always_comb begin
      w_merged = w_ram_word;
      for (int b = 0; b < 4; b++) begin
         if (w_strb[b]) w_merged[8*b +: 8] = w_wlane[8*b +: 8];
      end
   end

   always_comb begin
      w_rd_word = 32'h0;
      if (w_in_ram)         w_rd_word = w_merged >> w_shamt;
      else if (w_is_ser)    w_rd_word = {30'b0, w_txq_full, w_txq_empty};
      else if (w_is_rtc_lo) w_rd_word = r_rtc[31:0];
      else if (w_is_rtc_hi) w_rd_word = r_rtc_hi_snap;
   end

   // Gating on rstn_in keeps a store from landing while reset is held.
   always_ff @(posedge clk) begin
      if (rstn_in) begin
         for (int b = 0; b < 4; b++) begin
            if (w_strb[b]) r_ram[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn_in) begin
      if (!rstn_in) begin
         r_rdata       <= 32'h0;
         r_access_err  <= 1'b0;
         r_err_cnt     <= 8'h00;
         r_rtc         <= 64'h0;
         r_rtc_hi_snap <= 32'h0;
      end else begin
         r_rtc        <= r_rtc + 64'd1;
         r_access_err <= w_err;
         if (w_err && (r_err_cnt != 8'hff)) r_err_cnt <= r_err_cnt + 8'd1;
         if (mem_rd) begin
            r_rdata <= w_rd_word;
            if (w_is_rtc_lo) r_rtc_hi_snap <= r_rtc[63:32];
         end
      end
   end

   ysyx_23060180_txq #(
      .DEPTH (TXQ_DEPTH),
      .WIDTH (8)
   ) u_txq (
      .clk     (clk),
      .rstn_in (rstn_in),
      .i_push  (w_push),
      .i_data  (mem_wdata[7:0]),
      .i_pop   (w_pop),
      .o_full  (w_txq_full),
      .o_empty (w_txq_empty),
      .o_head  (tx_data)
   );

   assign tx_valid   = ~w_txq_empty;
   assign mem_rdata  = r_rdata;
   assign access_err = r_access_err;
   assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060180_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_23060180_mem_bridge
// Description : Self-checking bench with a byte-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060180_mem_bridge;
   localparam logic [31:0] c_SER = 32'ha000_03f8;
   localparam logic [31:0] c_RTC = 32'ha000_0048;
   localparam logic [31:0] c_RAM = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rstn_in;
   logic        mem_rd, mem_wr, tx_ready;
   logic [31:0] mem_raddr, mem_wdata;
   logic [3:0]  mem_wbit_en;
   logic [31:0] mem_rdata;
   logic        tx_valid, access_err;
   logic [7:0]  tx_data, err_cnt;

   int n_checks = 0;
   int n_errors = 0;
   bit skip_rd  = 1'b0;

   logic [7:0]  m_mem [int unsigned];
   logic [7:0]  m_q [$];
   logic [31:0] exp_rdata = 32'h0;
   logic        exp_err   = 1'b0;
   logic [7:0]  exp_cnt   = 8'h00;
   logic [63:0] m_rtc     = 64'h0;
   logic [31:0] m_snap    = 32'h0;

   always #5 clk = ~clk;

   ysyx_23060180_mem_bridge dut (
      .clk(clk), .rstn_in(rstn_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_raddr(mem_raddr), .mem_wdata(mem_wdata), .mem_wbit_en(mem_wbit_en),
      .mem_rdata(mem_rdata), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .access_err(access_err), .err_cnt(err_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input logic [31:0] act, input logic [31:0] lo, input logic [31:0] hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_errors++;
         $display("FAIL %s: got %h expected within %h..%h", name, act, lo, hi);
      end
   endtask

   function automatic bit in_ram(input logic [31:0] a);
      return (a >= c_RAM) && (a <= 32'h8000_ffff);
   endfunction

   function automatic bit size_ok(input logic [3:0] sz, input logic [31:0] a);
      return (sz == 4'd1) || (sz == 4'd2 && a[0] == 1'b0) || (sz == 4'd4 && a[1:0] == 2'b00);
   endfunction

   function automatic logic [7:0] rd_byte(input int unsigned off);
      return m_mem.exists(off) ? m_mem[off] : 8'h00;
   endfunction

   task automatic model_reset();
      exp_rdata = 32'h0; exp_err = 1'b0; exp_cnt = 8'h00;
      m_rtc = 64'h0; m_snap = 32'h0; m_q.delete();
   endtask

   task automatic model_step();
      bit err, full0, empty0;
      logic [31:0] a, r;
      int unsigned base;
      err = 1'b0; a = mem_raddr;
      full0 = (m_q.size() == 4); empty0 = (m_q.size() == 0);
      if (!empty0 && tx_ready) void'(m_q.pop_front());
      if (mem_wr) begin
         if (in_ram(a) && size_ok(mem_wbit_en, a)) begin
            for (int k = 0; k < int'(mem_wbit_en); k++) m_mem[a - c_RAM + k] = mem_wdata[8*k +: 8];
         end else if (a == c_SER && mem_wbit_en == 4'd1) begin
            if (m_q.size() < 4) m_q.push_back(mem_wdata[7:0]);
            else err = 1'b1;
         end else err = 1'b1;
      end
      if (mem_rd) begin
         if (in_ram(a)) begin
            r = 32'h0; base = (a & ~32'h3) - c_RAM;
            for (int k = int'(a[1:0]); k < 4; k++)
               r = r | (32'(rd_byte(base + k)) << (8 * (k - int'(a[1:0]))));
            exp_rdata = r;
         end else if (a == c_SER) exp_rdata = {30'b0, full0, empty0};
         else if (a == c_RTC) begin exp_rdata = m_rtc[31:0]; m_snap = m_rtc[63:32]; end
         else if (a == c_RTC + 32'd4) exp_rdata = m_snap;
         else begin exp_rdata = 32'h0; err = 1'b1; end
      end
      m_rtc   = m_rtc + 64'd1;
      exp_err = err;
      if (err && exp_cnt != 8'hff) exp_cnt = exp_cnt + 8'd1;
   endtask

   // Reference model advances on each edge; outputs are compared 1 time unit later.
   always @(posedge clk) begin
      if (!rstn_in) model_reset();
      else model_step();
      #1;
      if (!skip_rd) chk("rdata", mem_rdata, exp_rdata);
      chk("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
      chk("tx_data", 32'(tx_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
      chk("access_err", 32'(access_err), 32'(exp_err));
      chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
   end

   task automatic op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] sz);
      mem_rd = rd; mem_wr = wr; mem_raddr = a; mem_wdata = d; mem_wbit_en = sz;
      @(negedge clk);
      mem_rd = 1'b0; mem_wr = 1'b0;
   endtask

   task automatic idle();
      op(1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
   endtask

   initial begin
      logic [7:0] ch;
      rstn_in = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; tx_ready = 1'b0;
      mem_raddr = 32'h0; mem_wdata = 32'h0; mem_wbit_en = 4'd0;
      #1 rstn_in = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_rdata", mem_rdata, 32'h0);
      chk("reset_tx_valid", 32'(tx_valid), 32'h0);
      chk("reset_err_cnt", 32'(err_cnt), 32'h0);
      rstn_in = 1'b1;

      // word store then byte-offset read
      op(1'b0, 1'b1, 32'h8000_0000, 32'h1122_3344, 4'd4);
      op(1'b0, 1'b1, 32'h8000_0008, 32'h0102_0304, 4'd4);
      op(1'b1, 1'b0, 32'h8000_0003, 32'h0, 4'd0);
      chk("t1_rd_b3", mem_rdata, 32'h0000_0011);

      // sub-word stores and write-first read
      op(1'b0, 1'b1, 32'h8000_0001, 32'h0000_00ab, 4'd1);
      op(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'd0);
      chk("t2_sb", mem_rdata, 32'h1122_ab44);
      op(1'b0, 1'b1, 32'h8000_0002, 32'h0000_beef, 4'd2);
      op(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'd0);
      chk("t2_sh", mem_rdata, 32'hbeef_ab44);
      op(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0077, 4'd1);
      chk("t2_rw_same", mem_rdata, 32'hbeef_ab77);
      op(1'b1, 1'b0, 32'h8000_0002, 32'h0, 4'd0);
      chk("t2_rd_h2", mem_rdata, 32'h0000_beef);

      // illegal accesses
      op(1'b0, 1'b1, 32'h8000_0001, 32'h0000_5555, 4'd2);
      chk("t3_pulse", 32'(access_err), 32'h1);
      op(1'b0, 1'b1, 32'h8000_0002, 32'hdead_beef, 4'd4);
      op(1'b0, 1'b1, 32'h8000_0000, 32'hffff_ffff, 4'd3);
      chk("t3_err_cnt", 32'(err_cnt), 32'd3);
      op(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'd0);
      chk("t3_ram_kept", mem_rdata, 32'hbeef_ab77);
      chk("t3_no_pulse", 32'(access_err), 32'h0);
      op(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'd0);
      chk("t3_unmapped_rd", mem_rdata, 32'h0);
      op(1'b0, 1'b1, c_RTC, 32'h1234_5678, 4'd4);
      chk("t3_rtc_wr", 32'(err_cnt), 32'd5);

      // TX queue overflow and drain
      for (int i = 0; i < 5; i++) begin
         ch = 8'h61 + 8'(i);
         op(1'b0, 1'b1, c_SER, {24'h0, ch}, 4'd1);
      end
      chk("t4_overflow", 32'(err_cnt), 32'd6);
      op(1'b1, 1'b0, c_SER, 32'h0, 4'd0);
      chk("t4_status_full", mem_rdata, 32'h2);
      tx_ready = 1'b1;
      chk("t4_head_a", 32'(tx_data), 32'h61);
      for (int i = 1; i < 4; i++) begin
         idle();
         chk("t4_head", 32'(tx_data), 32'h61 + 32'(i));
      end
      idle();
      chk("t4_drained", 32'(tx_valid), 32'h0);
      op(1'b1, 1'b0, c_SER, 32'h0, 4'd0);
      chk("t4_status_empty", mem_rdata, 32'h1);
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ch = 8'h77 + 8'(i);
         op(1'b0, 1'b1, c_SER, {24'h0, ch}, 4'd1);
      end
      tx_ready = 1'b1;
      op(1'b0, 1'b1, c_SER, 32'h0000_0021, 4'd1);
      tx_ready = 1'b0;
      chk("t4_full_pushpop", 32'(err_cnt), 32'd6);
      chk("t4_head_x", 32'(tx_data), 32'h78);

      // RTC coherence across a low-word carry
      skip_rd = 1'b1;
      force dut.r_rtc = 64'h0000_0000_ffff_fff0;
      @(negedge clk);
      release dut.r_rtc;
      op(1'b1, 1'b0, c_RTC, 32'h0, 4'd0);
      chk_rng("t5_lo_pre", mem_rdata, 32'hffff_fff0, 32'hffff_fff8);
      repeat (20) idle();
      op(1'b1, 1'b0, c_RTC + 32'd4, 32'h0, 4'd0);
      chk("t5_hi_snap", mem_rdata, 32'h0);
      op(1'b1, 1'b0, c_RTC, 32'h0, 4'd0);
      chk_rng("t5_lo_post", mem_rdata, 32'h0000_0001, 32'h0000_0020);
      op(1'b1, 1'b0, c_RTC + 32'd4, 32'h0, 4'd0);
      chk("t5_hi_carry", mem_rdata, 32'h1);

      // error counter saturation
      repeat (260) op(1'b0, 1'b1, 32'h8000_0000, 32'h0, 4'd3);
      chk("sat_err_cnt", 32'(err_cnt), 32'hff);

      // asynchronous reset in the middle of a store
      mem_rd = 1'b1; mem_wr = 1'b1; mem_raddr = 32'h8000_0008;
      mem_wdata = 32'hcafe_f00d; mem_wbit_en = 4'd4;
      #2 rstn_in = 1'b0;
      model_reset();
      #1;
      chk("t6_rdata", mem_rdata, 32'h0);
      chk("t6_tx_valid", 32'(tx_valid), 32'h0);
      chk("t6_tx_data", 32'(tx_data), 32'h0);
      chk("t6_access_err", 32'(access_err), 32'h0);
      chk("t6_err_cnt", 32'(err_cnt), 32'h0);
      @(negedge clk);
      mem_rd = 1'b0; mem_wr = 1'b0; rstn_in = 1'b1; skip_rd = 1'b0;
      op(1'b1, 1'b0, 32'h8000_0008, 32'h0, 4'd0);
      chk("t6_word_kept", mem_rdata, 32'h0102_0304);
      op(1'b1, 1'b0, c_RTC, 32'h0, 4'd0);
      chk("t6_rtc_restart", mem_rdata, 32'h1);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
